axi_full_slave: RTL and testbench
=================================

// Module: axi_full_slave
// PURPOSE
//  AXI4 (full) memory-mapped responder serving the axi_master bus: word-addressed RAM with FIXED/INCR/WRAP bursts.
//  Sits on the far end of the master's five channels, independent write and read engines sharing one array.
//  Serves as the bench target for the master and as a scratch memory in integration builds.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width of awaddr/araddr
//  DATA_WIDTH  32   data width; only 32 supported (4 byte lanes)
//  ID_WIDTH    3    transaction ID width; echoed on bid/rid
//  MEM_DEPTH   128  number of 32-bit words; valid byte range 0 .. 4*MEM_DEPTH-1
// PORTS
//  s_axi_aclk     in   1           clock, all logic on rising edge
//  s_axi_areset   in   1           synchronous active-high reset
//  s_axi_awid     in   ID_WIDTH    write ID, captured on AW handshake
//  s_axi_awaddr   in   ADDR_WIDTH  write start byte address
//  s_axi_awlen    in   8           beats-1
//  s_axi_awsize   in   3           beat size; values >2 are treated as 2
//  s_axi_awburst  in   2           00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  s_axi_awvalid/awready  in/out 1 AW handshake
//  s_axi_wdata    in   32          write data
//  s_axi_wstrb    in   4           byte enables, bit i -> wdata[8i+7:8i]
//  s_axi_wlast    in   1           last write beat marker
//  s_axi_wvalid/wready    in/out 1 W handshake
//  s_axi_bid      out  ID_WIDTH    = captured awid
//  s_axi_bresp    out  2           00 OKAY, 10 SLVERR
//  s_axi_bvalid/bready    out/in 1 B handshake
//  s_axi_arid, araddr, arlen, arsize, arburst, arvalid/arready: read counterparts of the AW signals
//  s_axi_rid      out  ID_WIDTH    = captured arid
//  s_axi_rdata    out  32          read data
//  s_axi_rresp    out  2           per-beat response, same encoding as bresp
//  s_axi_rlast    out  1           high on final read beat
//  s_axi_rvalid/rready    out/in 1 R handshake
// BEHAVIOUR
//  Reset: awready=arready=1; wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
//   Both FSMs go to IDLE; RAM contents are NOT cleared. Reset mid-burst abandons it silently.
//  Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   W_IDLE: awready=1. On awvalid&awready capture id/addr/len/size/burst, set beat cnt=0 and err=0.
//    Then awready<=0, wready<=1 (first W accepted one cycle after the AW handshake).
//   W_DATA: each wvalid&wready writes the enabled lanes to mem[addr>>2] and advances addr.
//    A beat is the last when cnt==len. Then wready<=0 and bvalid<=1 next cycle (W_RESP).
//    Mismatch errors set err=1: wlast=1 before last beat, or wlast=0 on the last beat.
//    The burst still runs len+1 beats either way.
//   W_RESP: bresp = err ? 10 : 00. Hold bvalid until bready, then go to W_IDLE with awready<=1.
//  Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   On AR handshake capture fields, arready<=0. First rvalid is on the next cycle.
//   rdata/rresp/rlast stay stable while rvalid&!rready. On handshake the next beat is presented the following cycle.
//   Throughput is one beat per clock with rready held high.
//   After the beat with rlast=1 is accepted: rvalid<=0, arready<=1.
//  Address step per beat, B = 1<<min(size,2):
//   FIXED: address unchanged.
//   INCR: addr+B, ADDR_WIDTH wrap-around.
//   WRAP: boundary = (len+1)*B; addr = base | ((addr+B) & (boundary-1)), with base = start & ~(boundary-1).
//  Error rules (SLVERR = 2'b10):
//   Reserved burst 11, or WRAP with len not in {1,3,7,15}: whole burst errors.
//    Writes modify no memory; every read beat returns rdata=0, rresp=10.
//   Beat address >= 4*MEM_DEPTH: write beat dropped with err=1; read beat returns rdata=0, rresp=10.
//    Other beats of the same burst are unaffected.
//  Simultaneous read and write to the same word in the same cycle: read returns the OLD word.
//  Write and read engines run concurrently and never block each other.
// TESTING
//  Reset, then AW INCR addr=0x10 len=3 and 4 W beats 0xA..0xD strb=F -> bresp=00, bid=awid.
//   Then AR same -> 4 R beats 0xA..0xD, rlast only on beat 4.
//  Write 0xFFFFFFFF to 0x20, then write 0x12345678 strb=0101 -> read 0x20 returns 0xFF34FF78.
//  WRAP len=3 start 0x38 -> beats at 0x38,0x3C,0x30,0x34. FIXED len=2 to 0x40 -> only the 3rd beat remains.
//  AW addr=0x1FC len=1 (MEM_DEPTH=128) -> beat 0 written, beat 1 dropped, bresp=10.
//   A read of the same span gives rresp 00 then 10, rdata 0 on beat 2.
//  Read with rready toggling 1,0,0,1 and bready held 0 for 5 cycles -> data/valid stable, no lost beat, bvalid held.
//  Reset asserted mid write burst -> next cycle awready=1, wready=0, bvalid=0; a new burst completes normally.

Source files
------------

// File: rtl/axi_full_slave_if.sv
// AXI4 five-channel bundle between a master and the axi_full_slave responder.
// Handshake: a beat moves on a rising edge where valid and ready are both high; valid never waits for ready.
interface axi_full_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3
) ();
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_full_slave.sv
// AXI4 word-addressed RAM responder with FIXED/INCR/WRAP bursts.
// Independent write and read engines share one array; a same-cycle read of a word being written sees the old word.
module axi_full_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    axi_full_slave_if.slave      s_axi,
    output logic [1:0]           o_dbg_wstate,
    output logic [1:0]           o_dbg_rstate
);
    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam int                    LANES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} rstate_t;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [1:0]            sh;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        sh   = (size > 3'd2) ? 2'd2 : size[1:0];
        step = ADDR_WIDTH'(1) << sh;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sh) - ADDR_WIDTH'(1);
        inc  = a + step;
        case (burst)
            2'b00:   f_next_addr = a;
            2'b10:   f_next_addr = (a & ~mask) | (inc & mask);
            default: f_next_addr = inc;
        endcase
    endfunction

    // Reserved burst type, or a WRAP length other than 2/4/8/16 beats, poisons the whole burst.
    function automatic logic f_burst_bad(input logic [1:0] burst, input logic [7:0] len);
        f_burst_bad = (burst == 2'b11) ||
                      ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                             (len == 8'd7) || (len == 8'd15)));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write engine ----------------
    wstate_t               r_wstate;
    wstate_t               w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic [7:0]            r_wcnt;
    logic                  r_werr;
    logic                  r_wbad;
    logic [ID_WIDTH-1:0]   r_bid;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_w_last;
    logic w_w_inr;

    assign w_aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_w_hs   = s_axi.wvalid && s_axi.wready;
    assign w_w_last = (r_wcnt == r_wlen);
    assign w_w_inr  = (r_waddr < MEM_BYTES);

    always_comb begin
        w_wstate_nxt   = r_wstate;
        s_axi.awready  = 1'b0;
        s_axi.wready   = 1'b0;
        s_axi.bvalid   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi.awready = 1'b1;
                if (s_axi.awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && w_w_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_wbad   <= 1'b0;
            r_bid    <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_bid    <= s_axi.awid;
                r_waddr  <= s_axi.awaddr;
                r_wlen   <= s_axi.awlen;
                r_wsize  <= s_axi.awsize;
                r_wburst <= s_axi.awburst;
                r_wcnt   <= '0;
                r_wbad   <= f_burst_bad(s_axi.awburst, s_axi.awlen);
                r_werr   <= f_burst_bad(s_axi.awburst, s_axi.awlen);
            end
            if (w_w_hs) begin
                r_wcnt  <= r_wcnt + 8'd1;
                r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                // wlast disagreeing with the beat count, or a beat past the array, flags the burst.
                if ((s_axi.wlast != w_w_last) || !w_w_inr) r_werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_areset && w_w_hs && !r_wbad && w_w_inr) begin
            for (int b = 0; b < LANES; b++) begin
                if (s_axi.wstrb[b]) r_mem[r_waddr[IDX_W+1:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    assign s_axi.bid   = r_bid;
    assign s_axi.bresp = {r_werr, 1'b0};

    // ---------------- read engine ----------------
    rstate_t               r_rstate;
    rstate_t               w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic [7:0]            r_rcnt;
    logic                  r_rbad;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [ADDR_WIDTH-1:0] w_rnext_addr;
    logic [ADDR_WIDTH-1:0] w_rfetch_addr;
    logic                  w_rfetch_ok;

    assign w_ar_hs       = s_axi.arvalid && s_axi.arready;
    assign w_r_hs        = s_axi.rvalid && s_axi.rready;
    assign w_rnext_addr  = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
    // The word registered on this edge belongs to the beat presented next cycle.
    assign w_rfetch_addr = w_ar_hs ? s_axi.araddr : w_rnext_addr;
    assign w_rfetch_ok   = (w_ar_hs ? !f_burst_bad(s_axi.arburst, s_axi.arlen) : !r_rbad) &&
                           (w_rfetch_addr < MEM_BYTES);

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi.arready = 1'b1;
                if (s_axi.arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rbad   <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rid    <= s_axi.arid;
                r_raddr  <= s_axi.araddr;
                r_rlen   <= s_axi.arlen;
                r_rsize  <= s_axi.arsize;
                r_rburst <= s_axi.arburst;
                r_rbad   <= f_burst_bad(s_axi.arburst, s_axi.arlen);
                r_rcnt   <= '0;
                r_rlast  <= (s_axi.arlen == 8'd0);
                r_rdata  <= w_rfetch_ok ? r_mem[w_rfetch_addr[IDX_W+1:2]] : '0;
                r_rresp  <= w_rfetch_ok ? 2'b00 : 2'b10;
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_raddr <= w_rnext_addr;
                    r_rcnt  <= r_rcnt + 8'd1;
                    r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                    r_rdata <= w_rfetch_ok ? r_mem[w_rfetch_addr[IDX_W+1:2]] : '0;
                    r_rresp <= w_rfetch_ok ? 2'b00 : 2'b10;
                end
            end
        end
    end

    assign s_axi.rid   = r_rid;
    assign s_axi.rdata = r_rdata;
    assign s_axi.rresp = r_rresp;
    assign s_axi.rlast = r_rlast;

    assign o_dbg_wstate = r_wstate;
    assign o_dbg_rstate = r_rstate;
endmodule

// File: tb/tb_axi_full_slave.sv
// Directed self-checking bench for axi_full_slave: bursts, strobes, error responses, backpressure, reset.
module tb_axi_full_slave;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_w;
    logic [1:0] dbg_r;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];
    logic [31:0] got_d[$];
    logic [1:0]  got_r[$];
    logic        got_l[$];
    logic [2:0]  got_id;
    logic [2:0]  b_id;
    logic [1:0]  b_resp;

    axi_full_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(3)) s_axi ();

    axi_full_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(3), .MEM_DEPTH(128)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi        (s_axi),
        .o_dbg_wstate (dbg_w),
        .o_dbg_rstate (dbg_r)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic aw_send(input logic [2:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic hs = 1'b0;
        s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
        s_axi.awsize = 3'd2; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = s_axi.awready;
            @(posedge clk); #1;
        end
        s_axi.awvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL aw_timeout: awready 0 need 1"); end
    endtask

    task automatic ar_send(input logic [2:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic hs = 1'b0;
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
        s_axi.arsize = 3'd2; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = s_axi.arready;
            @(posedge clk); #1;
        end
        s_axi.arvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL ar_timeout: arready 0 need 1"); end
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic hs = 1'b0;
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = s_axi.wready;
            @(posedge clk); #1;
        end
        s_axi.wvalid = 1'b0;
        if (!hs) begin n_cmp++; n_fail++; $display("FAIL w_timeout: wready 0 need 1"); end
    endtask

    task automatic write_burst(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [31:0] first);
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) w_send(first + 32'(i), 4'hF, i == int'(len));
    endtask

    task automatic b_recv();
        logic got = 1'b0;
        s_axi.bready = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_axi.bvalid) begin got = 1'b1; b_id = s_axi.bid; b_resp = s_axi.bresp; end
            @(posedge clk); #1;
        end
        s_axi.bready = 1'b0;
        if (!got) begin n_cmp++; n_fail++; b_resp = 2'bxx; $display("FAIL b_timeout: bvalid 0 need 1"); end
    endtask

    task automatic do_read(input logic [2:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        got_d.delete(); got_r.delete(); got_l.delete();
        ar_send(id, addr, len, burst);
        s_axi.rready = 1'b1;
        for (int c = 0; c < 300 && got_d.size() <= int'(len); c++) begin
            if (s_axi.rvalid) begin
                if (got_d.size() == 0) got_id = s_axi.rid;
                got_d.push_back(s_axi.rdata); got_r.push_back(s_axi.rresp); got_l.push_back(s_axi.rlast);
            end
            @(posedge clk); #1;
        end
        s_axi.rready = 1'b0;
        if (got_d.size() <= int'(len)) begin n_cmp++; n_fail++; $display("FAIL r_timeout: %0d beats need %0d", got_d.size(), int'(len) + 1); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (s_axi.awready !== 1'b1) begin n_fail++; $display("FAIL rst_awready: %b need 1", s_axi.awready); end
        n_cmp++; if (s_axi.arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready: %b need 1", s_axi.arready); end
        n_cmp++; if (s_axi.wready  !== 1'b0) begin n_fail++; $display("FAIL rst_wready: %b need 0", s_axi.wready); end
        n_cmp++; if (s_axi.bvalid  !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: %b need 0", s_axi.bvalid); end
        n_cmp++; if (s_axi.rvalid  !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: %b need 0", s_axi.rvalid); end
        n_cmp++; if (s_axi.rlast   !== 1'b0) begin n_fail++; $display("FAIL rst_rlast: %b need 0", s_axi.rlast); end
        n_cmp++; if ({s_axi.bid, s_axi.bresp} !== 5'd0) begin n_fail++; $display("FAIL rst_b: %h need 0", {s_axi.bid, s_axi.bresp}); end
        n_cmp++; if ({s_axi.rid, s_axi.rresp, s_axi.rdata} !== 37'd0) begin n_fail++; $display("FAIL rst_r: %h need 0", {s_axi.rid, s_axi.rresp, s_axi.rdata}); end
    endtask

    task automatic test_incr();
        write_burst(3'd5, 32'h10, 8'd3, 2'b01, 32'hA);
        b_recv();
        n_cmp++; if (b_id !== 3'd5 || b_resp !== 2'b00) begin n_fail++; $display("FAIL incr_b: id %0d resp %b need 5/00", b_id, b_resp); end
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD}; exp_resp_q = '{2'b00, 2'b00, 2'b00, 2'b00};
        do_read(3'd3, 32'h10, 8'd3, 2'b01);
        n_cmp++; if (got_id !== 3'd3) begin n_fail++; $display("FAIL incr_rid: %0d need 3", got_id); end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i] || got_r[i] !== exp_resp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL incr_beat%0d: %h/%b/%b need %h/%b", i, got_d[i], got_r[i], got_l[i], exp_q[i], exp_resp_q[i]);
            end
        end
    endtask

    task automatic test_strobe();
        write_burst(3'd1, 32'h20, 8'd0, 2'b01, 32'hFFFF_FFFF);
        b_recv();
        aw_send(3'd1, 32'h20, 8'd0, 2'b01);
        w_send(32'h1234_5678, 4'b0101, 1'b1);
        b_recv();
        n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL strb_b: resp %b need 00", b_resp); end
        do_read(3'd1, 32'h20, 8'd0, 2'b01);
        n_cmp++; if (got_d.size() != 1 || got_d[0] !== 32'hFF34_FF78) begin n_fail++; $display("FAIL strb_data: %h need ff34ff78", got_d.size() > 0 ? got_d[0] : 32'hx); end
    endtask

    task automatic test_wrap_fixed();
        write_burst(3'd2, 32'h38, 8'd3, 2'b10, 32'h100);
        b_recv();
        n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL wrap_b: resp %b need 00", b_resp); end
        exp_q = '{32'h102, 32'h103, 32'h100, 32'h101};
        do_read(3'd2, 32'h30, 8'd3, 2'b01);
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_incr_rd%0d: %h need %h", i, got_d[i], exp_q[i]); end
        end
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103};
        do_read(3'd2, 32'h38, 8'd3, 2'b10);
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 3)) begin n_fail++; $display("FAIL wrap_rd%0d: %h/%b need %h", i, got_d[i], got_l[i], exp_q[i]); end
        end
        write_burst(3'd2, 32'h40, 8'd2, 2'b00, 32'h200);
        b_recv();
        do_read(3'd2, 32'h40, 8'd0, 2'b01);
        n_cmp++; if (got_d.size() != 1 || got_d[0] !== 32'h202) begin n_fail++; $display("FAIL fixed_data: %h need 202", got_d.size() > 0 ? got_d[0] : 32'hx); end
    endtask

    task automatic test_errors();
        write_burst(3'd3, 32'h1FC, 8'd1, 2'b01, 32'hBEEF_0001);
        b_recv();
        n_cmp++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL oob_b: resp %b need 10", b_resp); end
        exp_q = '{32'hBEEF_0001, 32'h0}; exp_resp_q = '{2'b00, 2'b10};
        do_read(3'd3, 32'h1FC, 8'd1, 2'b01);
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i] || got_r[i] !== exp_resp_q[i]) begin n_fail++; $display("FAIL oob_rd%0d: %h/%b need %h/%b", i, got_d[i], got_r[i], exp_q[i], exp_resp_q[i]); end
        end
        write_burst(3'd4, 32'h50, 8'd0, 2'b01, 32'h5555);
        b_recv();
        write_burst(3'd4, 32'h50, 8'd0, 2'b11, 32'h9999);
        b_recv();
        n_cmp++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL rsvd_b: resp %b need 10", b_resp); end
        write_burst(3'd4, 32'h50, 8'd2, 2'b10, 32'h7777);
        b_recv();
        n_cmp++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wraplen_b: resp %b need 10", b_resp); end
        do_read(3'd4, 32'h50, 8'd0, 2'b01);
        n_cmp++; if (got_d.size() != 1 || got_d[0] !== 32'h5555 || got_r[0] !== 2'b00) begin n_fail++; $display("FAIL bad_nowrite: %h need 5555", got_d.size() > 0 ? got_d[0] : 32'hx); end
        do_read(3'd4, 32'h50, 8'd1, 2'b11);
        for (int i = 0; i < got_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== 32'h0 || got_r[i] !== 2'b10) begin n_fail++; $display("FAIL rsvd_rd%0d: %h/%b need 0/10", i, got_d[i], got_r[i]); end
        end
        aw_send(3'd4, 32'h54, 8'd1, 2'b01);
        w_send(32'h61, 4'hF, 1'b1);
        w_send(32'h62, 4'hF, 1'b1);
        b_recv();
        n_cmp++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wlast_b: resp %b need 10", b_resp); end
    endtask

    task automatic test_backpressure();
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic stalled = 1'b0;
        int   wait_c = 0;
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        ar_send(3'd6, 32'h10, 8'd3, 2'b01);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            s_axi.rready = pat[c % 4];
            if (stalled) begin
                n_cmp++; if (s_axi.rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: rvalid %b need 1", s_axi.rvalid); end
            end
            if (s_axi.rvalid) begin
                n_cmp++;
                if (s_axi.rdata !== exp_q[0] || s_axi.rlast !== (exp_q.size() == 1)) begin
                    n_fail++; $display("FAIL bp_beat: %h/%b need %h", s_axi.rdata, s_axi.rlast, exp_q[0]);
                end
                if (s_axi.rready) void'(exp_q.pop_front());
            end
            stalled = s_axi.rvalid && !s_axi.rready;
            @(posedge clk); #1;
        end
        s_axi.rready = 1'b0;
        n_cmp++; if (exp_q.size() != 0 || s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin
            n_fail++; $display("FAIL bp_end: left %0d rvalid %b arready %b need 0/0/1", exp_q.size(), s_axi.rvalid, s_axi.arready);
        end
        write_burst(3'd4, 32'h84, 8'd0, 2'b01, 32'hCAFE_0000);
        while (!s_axi.bvalid && wait_c < 20) begin @(posedge clk); #1; wait_c++; end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (s_axi.bvalid !== 1'b1 || s_axi.bid !== 3'd4) begin n_fail++; $display("FAIL b_hold%0d: bvalid %b bid %0d need 1/4", c, s_axi.bvalid, s_axi.bid); end
            @(posedge clk); #1;
        end
        b_recv();
        n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL b_hold_resp: %b need 00", b_resp); end
    endtask

    task automatic test_reset_mid_burst();
        aw_send(3'd6, 32'h60, 8'd3, 2'b01);
        w_send(32'h301, 4'hF, 1'b0);
        w_send(32'h302, 4'hF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (s_axi.awready !== 1'b1 || s_axi.wready !== 1'b0 || s_axi.bvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst: awready %b wready %b bvalid %b need 1/0/0", s_axi.awready, s_axi.wready, s_axi.bvalid);
        end
        write_burst(3'd6, 32'h64, 8'd0, 2'b01, 32'h444);
        b_recv();
        n_cmp++; if (b_id !== 3'd6 || b_resp !== 2'b00) begin n_fail++; $display("FAIL midrst_b: id %0d resp %b need 6/00", b_id, b_resp); end
        do_read(3'd6, 32'h64, 8'd0, 2'b01);
        n_cmp++; if (got_d.size() != 1 || got_d[0] !== 32'h444) begin n_fail++; $display("FAIL midrst_rd: %h need 444", got_d.size() > 0 ? got_d[0] : 32'hx); end
    endtask

    task automatic test_back_to_back();
        write_burst(3'd0, 32'h70, 8'd0, 2'b01, 32'h1111);
        b_recv();
        s_axi.awid = 3'd0; s_axi.awaddr = 32'h70; s_axi.awlen = 8'd0; s_axi.awsize = 3'd2;
        s_axi.awburst = 2'b01; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h2222; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        s_axi.arid = 3'd1; s_axi.araddr = 32'h70; s_axi.arlen = 8'd0; s_axi.arsize = 3'd2;
        s_axi.arburst = 2'b01; s_axi.arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        n_cmp++; if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h1111) begin
            n_fail++; $display("FAIL collide_old: rvalid %b rdata %h need 1/1111", s_axi.rvalid, s_axi.rdata);
        end
        s_axi.rready = 1'b1;
        @(posedge clk); #1;
        s_axi.rready = 1'b0;
        b_recv();
        n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL collide_b: %b need 00", b_resp); end
        do_read(3'd1, 32'h70, 8'd0, 2'b01);
        n_cmp++; if (got_d.size() != 1 || got_d[0] !== 32'h2222) begin n_fail++; $display("FAIL collide_new: %h need 2222", got_d.size() > 0 ? got_d[0] : 32'hx); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_wrap_fixed();
        test_errors();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
